// File: rtl/alu_issue_if.sv
// Issue-controller bus bundle: instruction intake, ALU start/operands/result,
// register writeback and illegal-encoding flag.
interface alu_issue_if;
   logic        instr_valid_i;
   logic        instr_ready_o;
   logic [31:0] instr_i;
   logic [31:0] rs1_data_i;
   logic [31:0] rs2_data_i;
   logic        alu_start_o;
   logic [31:0] alu_in1_o;
   logic [31:0] alu_in2_o;
   logic [2:0]  alu_op_o;
   logic        alu_op_qual_o;
   logic        alu_op_ext_o;
   logic [31:0] alu_out_i;
   logic        alu_busy_i;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic        wb_ready_i;
   logic        illegal_o;

   // Controller side
   modport master (
      input  instr_valid_i, instr_i, rs1_data_i, rs2_data_i,
             alu_out_i, alu_busy_i, wb_ready_i,
      output instr_ready_o, alu_start_o, alu_in1_o, alu_in2_o,
             alu_op_o, alu_op_qual_o, alu_op_ext_o,
             wb_valid_o, wb_rd_o, wb_data_o, illegal_o
   );

   // Decode stage, ALU and register file side
   modport slave (
      output instr_valid_i, instr_i, rs1_data_i, rs2_data_i,
             alu_out_i, alu_busy_i, wb_ready_i,
      input  instr_ready_o, alu_start_o, alu_in1_o, alu_in2_o,
             alu_op_o, alu_op_qual_o, alu_op_ext_o,
             wb_valid_o, wb_rd_o, wb_data_o, illegal_o
   );
endinterface

// File: rtl/alu_issue.sv
// Execute-stage issue controller: decodes OP/OP-IMM (incl. M-extension),
// drives the ALU with registered operands and returns the result via writeback.
module alu_issue (
   input  logic        clk,
   input  logic        reset_i,
   alu_issue_if.master bus
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned RD_W = 5;
   localparam int unsigned OP_W = 3;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MEXT   = 7'b0000001;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_e;

   state_e            state_q, state_d;
   logic              ready_q, ready_d;
   logic              start_q, start_d;
   logic [XLEN-1:0]   in1_q, in1_d;
   logic [XLEN-1:0]   in2_q, in2_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic              qual_q, qual_d;
   logic              ext_q, ext_d;
   logic              wb_valid_q, wb_valid_d;
   logic [RD_W-1:0]   rd_q, rd_d;
   logic [XLEN-1:0]   wb_data_q, wb_data_d;
   logic              illegal_q, illegal_d;

   logic [6:0]        opcode_c;
   logic [6:0]        funct7_c;
   logic [OP_W-1:0]   funct3_c;
   logic [RD_W-1:0]   rd_c;
   logic [XLEN-1:0]   imm_c;
   logic [XLEN-1:0]   dec_in2_c;
   logic              dec_qual_c;
   logic              dec_ext_c;
   logic              dec_illegal_c;
   logic              unused_rs1_field;

   assign opcode_c = bus.instr_i[6:0];
   assign rd_c     = bus.instr_i[11:7];
   assign funct3_c = bus.instr_i[14:12];
   assign funct7_c = bus.instr_i[31:25];
   assign imm_c    = {{(XLEN-12){bus.instr_i[31]}}, bus.instr_i[31:20]};
   // Register indices arrive already resolved as rs1/rs2 data.
   assign unused_rs1_field = ^bus.instr_i[19:15];

   // Instruction decode; anything not explicitly recognised is illegal
   always_comb begin
      dec_illegal_c = 1'b1;
      dec_qual_c    = 1'b0;
      dec_ext_c     = 1'b0;
      dec_in2_c     = bus.rs2_data_i;
      case (opcode_c)
         OPC_OP: begin
            if (funct7_c == F7_BASE) begin
               dec_illegal_c = 1'b0;
            end else if (funct7_c == F7_ALT &&
                         (funct3_c == 3'b000 || funct3_c == 3'b101)) begin
               dec_illegal_c = 1'b0;
               dec_qual_c    = 1'b1;
            end else if (funct7_c == F7_MEXT) begin
               dec_illegal_c = 1'b0;
               dec_ext_c     = 1'b1;
            end
         end
         OPC_OPIMM: begin
            dec_in2_c = imm_c;
            case (funct3_c)
               3'b001: dec_illegal_c = (funct7_c != F7_BASE);
               3'b101: begin
                  if (funct7_c == F7_BASE) begin
                     dec_illegal_c = 1'b0;
                  end else if (funct7_c == F7_ALT) begin
                     dec_illegal_c = 1'b0;
                     dec_qual_c    = 1'b1;
                  end
               end
               default: dec_illegal_c = 1'b0;
            endcase
         end
         default: dec_illegal_c = 1'b1;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      in1_d      = in1_q;
      in2_d      = in2_q;
      op_d       = op_q;
      qual_d     = qual_q;
      ext_d      = ext_q;
      wb_valid_d = wb_valid_q;
      rd_d       = rd_q;
      wb_data_d  = wb_data_q;
      illegal_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.instr_valid_i) begin
               in1_d  = bus.rs1_data_i;
               in2_d  = dec_in2_c;
               op_d   = funct3_c;
               qual_d = dec_qual_c;
               ext_d  = dec_ext_c;
               rd_d   = rd_c;
               if (dec_illegal_c) begin
                  illegal_d = 1'b1;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (!bus.alu_busy_i) begin
               wb_data_d = bus.alu_out_i;
               state_d   = (rd_q == RD_W'(0)) ? S_IDLE : S_WB;
            end
         end
         S_WB: begin
            // First WB cycle raises valid; it then holds until accepted.
            if (wb_valid_q && bus.wb_ready_i) begin
               wb_valid_d = 1'b0;
               state_d    = S_IDLE;
            end else begin
               wb_valid_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      start_d = (state_d == S_ISSUE);
      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         ready_q    <= 1'b1;
         start_q    <= 1'b0;
         in1_q      <= '0;
         in2_q      <= '0;
         op_q       <= '0;
         qual_q     <= 1'b0;
         ext_q      <= 1'b0;
         wb_valid_q <= 1'b0;
         rd_q       <= '0;
         wb_data_q  <= '0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         start_q    <= start_d;
         in1_q      <= in1_d;
         in2_q      <= in2_d;
         op_q       <= op_d;
         qual_q     <= qual_d;
         ext_q      <= ext_d;
         wb_valid_q <= wb_valid_d;
         rd_q       <= rd_d;
         wb_data_q  <= wb_data_d;
         illegal_q  <= illegal_d;
      end
   end

   assign bus.instr_ready_o = ready_q;
   assign bus.alu_start_o   = start_q;
   assign bus.alu_in1_o     = in1_q;
   assign bus.alu_in2_o     = in2_q;
   assign bus.alu_op_o      = op_q;
   assign bus.alu_op_qual_o = qual_q;
   assign bus.alu_op_ext_o  = ext_q;
   assign bus.wb_valid_o    = wb_valid_q;
   assign bus.wb_rd_o       = rd_q;
   assign bus.wb_data_o     = wb_data_q;
   assign bus.illegal_o     = illegal_q;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: vector table for single instructions plus
// hand sequences for a long DIV, writeback backpressure and mid-op reset.
module tb_alu_issue;
   logic clk = 1'b0;
   logic reset_i;
   int   n_cmp = 0;
   int   n_bad = 0;

   alu_issue_if bus ();

   alu_issue dut (
      .clk     (clk),
      .reset_i (reset_i),
      .bus     (bus.master)
   );

   always #5 clk = ~clk;

   // ALU model: M ops hold busy for 33 cycles; output is junk while busy
   logic [5:0] busy_cnt;
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) busy_cnt <= 6'd0;
      else if (bus.alu_start_o && bus.alu_op_ext_o) busy_cnt <= 6'd33;
      else if (busy_cnt != 6'd0) busy_cnt <= busy_cnt - 6'd1;
   end
   assign bus.alu_busy_i = (busy_cnt != 6'd0);

   function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic q, input logic e);
      if (e) begin
         if (op == 3'd0) return a * b;
         if (op == 3'd4) begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            return $signed(a) / $signed(b);
         end
         return 32'd0;
      end
      case (op)
         3'd0: begin
            if (q) return a - b;
            return a + b;
         end
         3'd1: return a << b[4:0];
         3'd2: return {31'd0, $signed(a) < $signed(b)};
         3'd3: return {31'd0, a < b};
         3'd4: return a ^ b;
         3'd5: begin
            if (q) return $signed(a) >>> b[4:0];
            return a >> b[4:0];
         end
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   always_comb begin
      if (bus.alu_busy_i) bus.alu_out_i = 32'hDEAD_BEEF;
      else bus.alu_out_i = alu_ref(bus.alu_in1_o, bus.alu_in2_o, bus.alu_op_o,
                                   bus.alu_op_qual_o, bus.alu_op_ext_o);
   end

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic        illegal;
      logic [31:0] in2;
      logic [2:0]  op;
      logic        qual;
      logic        ext;
      logic [4:0]  rd;
      logic [31:0] data;
   } vec_t;

   localparam int NVEC = 9;
   vec_t vecs [NVEC];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_zero(input string p);
      chk({p, "_ready"},   32'(bus.instr_ready_o), 32'd1);
      chk({p, "_start"},   32'(bus.alu_start_o),   32'd0);
      chk({p, "_wbvalid"}, 32'(bus.wb_valid_o),    32'd0);
      chk({p, "_illegal"}, 32'(bus.illegal_o),     32'd0);
      chk({p, "_in1"},     bus.alu_in1_o,          32'd0);
      chk({p, "_in2"},     bus.alu_in2_o,          32'd0);
      chk({p, "_opfields"}, 32'({bus.alu_op_o, bus.alu_op_qual_o, bus.alu_op_ext_o}), 32'd0);
      chk({p, "_wbrd"},    32'(bus.wb_rd_o),       32'd0);
      chk({p, "_wbdata"},  bus.wb_data_o,          32'd0);
   endtask

   // Issue one table vector with wb_ready_i=1 and check the exact cycle timing
   task automatic run_vec(input int i);
      vec_t v;
      v = vecs[i];
      bus.instr_i       = v.instr;
      bus.rs1_data_i    = v.rs1;
      bus.rs2_data_i    = v.rs2;
      bus.instr_valid_i = 1'b1;
      bus.wb_ready_i    = 1'b1;
      tick();
      bus.instr_valid_i = 1'b0;
      chk($sformatf("v%0d_illegal", i), 32'(bus.illegal_o), 32'(v.illegal));
      if (v.illegal) begin
         chk($sformatf("v%0d_nostart", i), 32'(bus.alu_start_o), 32'd0);
         chk($sformatf("v%0d_ready", i), 32'(bus.instr_ready_o), 32'd1);
         tick();
         chk($sformatf("v%0d_illegal_pulse", i),
             32'({bus.illegal_o, bus.alu_start_o, bus.wb_valid_o}), 32'd0);
      end else begin
         chk($sformatf("v%0d_start", i), 32'(bus.alu_start_o), 32'd1);
         chk($sformatf("v%0d_in1", i), bus.alu_in1_o, v.rs1);
         chk($sformatf("v%0d_in2", i), bus.alu_in2_o, v.in2);
         chk($sformatf("v%0d_opfields", i),
             32'({bus.alu_op_o, bus.alu_op_qual_o, bus.alu_op_ext_o}),
             32'({v.op, v.qual, v.ext}));
         chk($sformatf("v%0d_busy_ready", i), 32'(bus.instr_ready_o), 32'd0);
         tick();
         chk($sformatf("v%0d_start_1cyc", i), 32'(bus.alu_start_o), 32'd0);
         tick();
         chk($sformatf("v%0d_wb_early", i), 32'(bus.wb_valid_o), 32'd0);
         if (v.rd == 5'd0) begin
            chk($sformatf("v%0d_rd0_idle", i), 32'(bus.instr_ready_o), 32'd1);
            tick();
            chk($sformatf("v%0d_rd0_nowb", i), 32'(bus.wb_valid_o), 32'd0);
         end else begin
            tick();
            chk($sformatf("v%0d_wbvalid", i), 32'(bus.wb_valid_o), 32'd1);
            chk($sformatf("v%0d_wbrd", i), 32'(bus.wb_rd_o), 32'(v.rd));
            chk($sformatf("v%0d_wbdata", i), bus.wb_data_o, v.data);
            tick();
            chk($sformatf("v%0d_wb_done", i),
                32'({bus.wb_valid_o, bus.instr_ready_o}), 32'b01);
         end
      end
   endtask

   initial begin
      // instr, rs1, rs2, illegal, in2, op, qual, ext, rd, data
      vecs[0] = '{32'h0020_81B3, 32'd5, 32'd7, 1'b0, 32'd7, 3'd0, 1'b0, 1'b0, 5'd3, 32'd12};
      vecs[1] = '{32'h4043_5293, 32'h8000_0000, 32'd0, 1'b0, 32'h0000_0404, 3'd5, 1'b1, 1'b0,
                  5'd5, 32'hF800_0000};
      vecs[2] = '{32'hFFF0_0093, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b0,
                  5'd1, 32'hFFFF_FFFF};
      vecs[3] = '{32'h4020_8233, 32'd10, 32'd3, 1'b0, 32'd3, 3'd0, 1'b1, 1'b0, 5'd4, 32'd7};
      vecs[4] = '{32'h7FF0_C393, 32'h0000_F0F0, 32'd0, 1'b0, 32'h0000_07FF, 3'd4, 1'b0, 1'b0,
                  5'd7, 32'h0000_F70F};
      vecs[5] = '{32'h4020_9233, 32'd1, 32'd2, 1'b1, 32'd0, 3'd0, 1'b0, 1'b0, 5'd0, 32'd0};
      vecs[6] = '{32'h0020_8063, 32'd1, 32'd2, 1'b1, 32'd0, 3'd0, 1'b0, 1'b0, 5'd0, 32'd0};
      vecs[7] = '{32'h4030_9113, 32'd1, 32'd2, 1'b1, 32'd0, 3'd0, 1'b0, 1'b0, 5'd0, 32'd0};
      vecs[8] = '{32'h0020_8033, 32'd9, 32'd4, 1'b0, 32'd4, 3'd0, 1'b0, 1'b0, 5'd0, 32'd13};

      reset_i           = 1'b1;
      bus.instr_valid_i = 1'b0;
      bus.instr_i       = 32'd0;
      bus.rs1_data_i    = 32'd0;
      bus.rs2_data_i    = 32'd0;
      bus.wb_ready_i    = 1'b0;
      tick();
      tick();
      chk_idle_zero("reset");
      reset_i = 1'b0;
      tick();

      for (int i = 0; i < NVEC; i++) run_vec(i);

      // DIV x8,x1,x2 with a long busy window and writeback backpressure
      begin
         int busy_cycles;
         logic [31:0] held;
         busy_cycles = 0;
         bus.instr_i       = 32'h0220_C433;
         bus.rs1_data_i    = 32'hFFFF_FF9C;
         bus.rs2_data_i    = 32'd7;
         bus.wb_ready_i    = 1'b0;
         bus.instr_valid_i = 1'b1;
         tick();
         bus.instr_valid_i = 1'b0;
         chk("div_start", 32'({bus.alu_start_o, bus.alu_op_ext_o, bus.alu_op_o}), 32'b11100);
         tick();
         while (bus.alu_busy_i && busy_cycles < 100) begin
            busy_cycles++;
            if (bus.wb_valid_o) chk("div_wb_while_busy", 32'(bus.wb_valid_o), 32'd0);
            tick();
         end
         chk("div_busy_len", 32'(busy_cycles), 32'd33);
         tick();
         chk("div_capture_no_valid", 32'(bus.wb_valid_o), 32'd0);
         tick();
         chk("div_wbvalid", 32'(bus.wb_valid_o), 32'd1);
         chk("div_wbrd", 32'(bus.wb_rd_o), 32'd8);
         chk("div_wbdata", bus.wb_data_o, 32'hFFFF_FFF2);
         held = 32'hFFFF_FFF2;
         for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("div_hold%0d", k),
                32'({bus.wb_valid_o, bus.instr_ready_o}), 32'b10);
            chk($sformatf("div_hold_data%0d", k), bus.wb_data_o, held);
         end
         bus.wb_ready_i = 1'b1;
         tick();
         chk("div_wb_done", 32'({bus.wb_valid_o, bus.instr_ready_o}), 32'b01);
      end

      // MUL x9,x1,x2 reset while waiting on the ALU
      begin
         int stray;
         stray = 0;
         bus.instr_i       = 32'h0220_84B3;
         bus.rs1_data_i    = 32'd6;
         bus.rs2_data_i    = 32'd7;
         bus.instr_valid_i = 1'b1;
         tick();
         bus.instr_valid_i = 1'b0;
         tick();
         tick();
         tick();
         chk("mul_in_wait", 32'({bus.instr_ready_o, bus.alu_busy_i}), 32'b01);
         reset_i = 1'b1;
         #1;
         chk_idle_zero("midreset");
         tick();
         reset_i = 1'b0;
         for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.wb_valid_o || bus.alu_start_o) stray++;
         end
         chk("post_reset_no_wb", 32'(stray), 32'd0);
         chk("post_reset_ready", 32'(bus.instr_ready_o), 32'd1);
      end

      run_vec(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
